// File: rtl/demux_stream_n_pkg.sv
// Shared definitions for the stream demultiplexer: steering modes and
// the round-robin pointer wrap helper.
package demux_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/demux_stream_n_if.sv
// Producer/consumer bundle of the 1-to-N stream demux; the slave modport is
// the demux side, the master modport is the producer plus consumers.
interface demux_stream_n_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_CH   = 4,
   parameter int unsigned CNT_W  = 8
);
   localparam int unsigned SEL_W = $clog2(N_CH);

   logic                     mode;
   logic [DATA_W-1:0]        in_data;
   logic [SEL_W-1:0]         in_sel;
   logic                     in_valid;
   logic                     in_ready;
   logic [N_CH*DATA_W-1:0]   out_data;
   logic [N_CH-1:0]          out_valid;
   logic [N_CH-1:0]          out_ready;
   logic [SEL_W-1:0]         rr_ptr;
   logic [CNT_W-1:0]         err_cnt;

   modport master (
      output mode, in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid, rr_ptr, err_cnt
   );

   modport slave (
      input  mode, in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_valid, rr_ptr, err_cnt
   );

endinterface

// File: rtl/demux_stream_n_chan_reg.sv
// One-entry output register for a single demux channel: fill, drain, hold.
module demux_chan_reg #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              free_o
);
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   // A fill always wins over a drain so drain+fill in one cycle keeps valid high.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (fill_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demux: target decode, input handshake,
// round-robin pointer and saturating drop counter; per-channel registers below.
module demux_stream_n
   import demux_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_CH   = 4,
   parameter int unsigned CNT_W  = 8
) (
   input logic             clk,
   input logic             rst,
   demux_stream_n_if.slave bus
);
   localparam int unsigned SEL_W = $clog2(N_CH);

   logic [SEL_W-1:0]       tgt;
   int unsigned            tgt_idx;
   logic                   tgt_ok;
   logic                   accept;
   logic [N_CH-1:0]        chan_free;
   logic [(1<<SEL_W)-1:0]  free_pad;
   logic [N_CH-1:0]        fill;
   logic [N_CH-1:0]        valid_w;
   logic [N_CH*DATA_W-1:0] data_w;
   logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

   assign tgt     = (mode_e'(bus.mode) == MODE_RR) ? rr_ptr_q : bus.in_sel;
   assign tgt_idx = 32'(tgt);
   assign tgt_ok  = tgt_idx < N_CH;

   // Unused select codes read as "free" so out-of-range beats are accepted and dropped.
   always_comb begin
      free_pad = '1;
      free_pad[N_CH-1:0] = chan_free;
   end

   assign bus.in_ready = !rst && free_pad[tgt];
   assign accept       = bus.in_valid && bus.in_ready;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      localparam int unsigned K = k;
      assign fill[k] = accept && (tgt_idx == K);

      demux_chan_reg #(.DATA_W(DATA_W)) u_chan (
         .clk     (clk),
         .rst     (rst),
         .fill_i  (fill[k]),
         .data_i  (bus.in_data),
         .ready_i (bus.out_ready[k]),
         .valid_o (valid_w[k]),
         .data_o  (data_w[k*DATA_W +: DATA_W]),
         .free_o  (chan_free[k])
      );
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      err_cnt_d = err_cnt_q;
      if (accept && (mode_e'(bus.mode) == MODE_RR)) begin
         rr_ptr_d = SEL_W'(rr_next(32'(rr_ptr_q), N_CH));
      end
      if (accept && !tgt_ok && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.out_valid = valid_w;
   assign bus.out_data  = data_w;
   assign bus.rr_ptr    = rr_ptr_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Directed self-checking bench for demux_stream_n with a 4-channel and a
// 3-channel instance sharing one clock.
module tb_demux_stream_n;
   logic clk;
   logic rst_a, rst_b;
   int   n_cmp, n_bad;

   demux_stream_n_if #(.DATA_W(8), .N_CH(4), .CNT_W(8)) a ();
   demux_stream_n_if #(.DATA_W(8), .N_CH(3), .CNT_W(8)) b ();

   demux_stream_n #(.DATA_W(8), .N_CH(4), .CNT_W(8)) u4 (.clk(clk), .rst(rst_a), .bus(a));
   demux_stream_n #(.DATA_W(8), .N_CH(3), .CNT_W(8)) u3 (.clk(clk), .rst(rst_b), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_a = 1'b1; rst_b = 1'b1;
      a.mode = 1'b0; a.in_sel = 2'd0; a.in_data = 8'hEE; a.in_valid = 1'b1; a.out_ready = 4'b0000;
      b.mode = 1'b0; b.in_sel = 2'd0; b.in_data = 8'hEE; b.in_valid = 1'b1; b.out_ready = 3'b000;
      tick; tick;
      n_cmp++; if (a.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_a got %0b exp 0", a.in_ready); end
      n_cmp++; if (b.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_b got %0b exp 0", b.in_ready); end
      n_cmp++; if (a.out_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0000", a.out_valid); end
      n_cmp++; if (a.out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data got %h exp 0", a.out_data); end
      n_cmp++; if (a.rr_ptr !== 2'd0 || a.err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_ptr_cnt got %0d/%0d exp 0/0", a.rr_ptr, a.err_cnt); end
      a.in_valid = 1'b0; b.in_valid = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      tick;
   endtask

   task automatic test_sel_fanout;
      a.mode = 1'b0; a.out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         a.in_sel = 2'(i); a.in_data = 8'hA0 + 8'(i); a.in_valid = 1'b1;
         #1;
         n_cmp++; if (a.in_ready !== 1'b1) begin n_bad++; $display("FAIL sel_in_ready[%0d] got %0b exp 1", i, a.in_ready); end
         tick;
         n_cmp++; if (a.out_valid !== 4'(1 << i)) begin n_bad++; $display("FAIL sel_valid[%0d] got %b exp %b", i, a.out_valid, 4'(1 << i)); end
         n_cmp++; if (a.out_data[i*8 +: 8] !== 8'hA0 + 8'(i)) begin n_bad++; $display("FAIL sel_data[%0d] got %h exp %h", i, a.out_data[i*8 +: 8], 8'hA0 + 8'(i)); end
      end
      a.in_valid = 1'b0;
      tick;
      n_cmp++; if (a.out_valid !== 4'b0000) begin n_bad++; $display("FAIL sel_drained got %b exp 0000", a.out_valid); end
   endtask

   task automatic test_backpressure;
      a.mode = 1'b0; a.out_ready = 4'b1011;
      a.in_sel = 2'd2; a.in_data = 8'h11; a.in_valid = 1'b1;
      #1;
      n_cmp++; if (a.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready got %0b exp 1", a.in_ready); end
      tick;
      a.in_data = 8'h22;
      #1;
      n_cmp++; if (a.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_blocked_ready got %0b exp 0", a.in_ready); end
      tick;
      n_cmp++; if (a.out_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_hold_valid got %b exp 0100", a.out_valid); end
      n_cmp++; if (a.out_data[23:16] !== 8'h11) begin n_bad++; $display("FAIL bp_hold_data got %h exp 11", a.out_data[23:16]); end
      n_cmp++; if (a.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_still_blocked got %0b exp 0", a.in_ready); end
      a.out_ready = 4'b1111;
      #1;
      n_cmp++; if (a.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %0b exp 1", a.in_ready); end
      tick;
      a.in_valid = 1'b0;
      n_cmp++; if (a.out_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_refill_valid got %b exp 0100", a.out_valid); end
      n_cmp++; if (a.out_data[23:16] !== 8'h22) begin n_bad++; $display("FAIL bp_refill_data got %h exp 22", a.out_data[23:16]); end
      tick;
      n_cmp++; if (a.out_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_empty got %b exp 0000", a.out_valid); end
   endtask

   task automatic test_rr;
      b.mode = 1'b1; b.out_ready = 3'b111; b.in_sel = 2'd3;
      for (int i = 0; i < 6; i++) begin
         b.in_data = 8'(i + 1); b.in_valid = 1'b1;
         #1;
         n_cmp++; if (b.rr_ptr !== 2'(i % 3)) begin n_bad++; $display("FAIL rr_ptr[%0d] got %0d exp %0d", i, b.rr_ptr, i % 3); end
         n_cmp++; if (b.in_ready !== 1'b1) begin n_bad++; $display("FAIL rr_ready[%0d] got %0b exp 1", i, b.in_ready); end
         tick;
         n_cmp++; if (b.out_valid !== 3'(1 << (i % 3))) begin n_bad++; $display("FAIL rr_valid[%0d] got %b exp %b", i, b.out_valid, 3'(1 << (i % 3))); end
         n_cmp++; if (b.out_data[(i%3)*8 +: 8] !== 8'(i + 1)) begin n_bad++; $display("FAIL rr_data[%0d] got %h exp %h", i, b.out_data[(i%3)*8 +: 8], 8'(i + 1)); end
      end
      b.in_valid = 1'b0;
      tick;
      n_cmp++; if (b.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL rr_wrap got %0d exp 0", b.rr_ptr); end
   endtask

   task automatic test_err_sat;
      int exp_cnt;
      b.mode = 1'b0; b.in_sel = 2'd3; b.in_data = 8'h5A; b.in_valid = 1'b1; b.out_ready = 3'b111;
      for (int i = 0; i < 300; i++) begin
         #1;
         n_cmp++; if (b.in_ready !== 1'b1) begin n_bad++; $display("FAIL err_ready[%0d] got %0b exp 1", i, b.in_ready); end
         tick;
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         n_cmp++; if (b.err_cnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL err_cnt[%0d] got %0d exp %0d", i, b.err_cnt, exp_cnt); end
      end
      b.in_valid = 1'b0;
      n_cmp++; if (b.out_valid !== 3'b000) begin n_bad++; $display("FAIL err_no_valid got %b exp 000", b.out_valid); end
      n_cmp++; if (b.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL err_rr_hold got %0d exp 0", b.rr_ptr); end
   endtask

   task automatic test_reset_mid;
      rst_b = 1'b1; tick; rst_b = 1'b0;
      b.mode = 1'b0; b.in_sel = 2'd3; b.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick;
      b.mode = 1'b1; b.out_ready = 3'b101; b.in_data = 8'h44;
      tick;
      b.in_data = 8'h55;
      tick;
      b.in_valid = 1'b0;
      tick;
      n_cmp++; if (b.rr_ptr !== 2'd2 || b.err_cnt !== 8'd4) begin n_bad++; $display("FAIL mid_pre_state got %0d/%0d exp 2/4", b.rr_ptr, b.err_cnt); end
      n_cmp++; if (b.out_valid !== 3'b010 || b.out_data[15:8] !== 8'h55) begin n_bad++; $display("FAIL mid_pre_hold got %b/%h exp 010/55", b.out_valid, b.out_data[15:8]); end
      rst_b = 1'b1; b.in_valid = 1'b1; b.in_data = 8'h77;
      #1;
      n_cmp++; if (b.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got %0b exp 0", b.in_ready); end
      tick;
      n_cmp++; if (b.out_valid !== 3'b000 || b.out_data !== 24'h0) begin n_bad++; $display("FAIL mid_rst_out got %b/%h exp 000/0", b.out_valid, b.out_data); end
      n_cmp++; if (b.rr_ptr !== 2'd0 || b.err_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_rst_state got %0d/%0d exp 0/0", b.rr_ptr, b.err_cnt); end
      n_cmp++; if (b.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready2 got %0b exp 0", b.in_ready); end
      rst_b = 1'b0; b.out_ready = 3'b000; b.in_data = 8'h66;
      #1;
      n_cmp++; if (b.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_first_ready got %0b exp 1", b.in_ready); end
      tick;
      b.in_valid = 1'b0;
      n_cmp++; if (b.out_valid !== 3'b001 || b.out_data[7:0] !== 8'h66) begin n_bad++; $display("FAIL mid_first_beat got %b/%h exp 001/66", b.out_valid, b.out_data[7:0]); end
   endtask

   task automatic test_mode_switch;
      a.out_ready = 4'b1111; a.mode = 1'b1; a.in_sel = 2'd0; a.in_data = 8'h70; a.in_valid = 1'b1;
      tick;
      n_cmp++; if (a.rr_ptr !== 2'd1) begin n_bad++; $display("FAIL ms_rr_start got %0d exp 1", a.rr_ptr); end
      a.mode = 1'b0; a.in_sel = 2'd3; a.in_data = 8'h73;
      tick;
      n_cmp++; if (a.out_valid !== 4'b1000 || a.out_data[31:24] !== 8'h73) begin n_bad++; $display("FAIL ms_sel_beat got %b/%h exp 1000/73", a.out_valid, a.out_data[31:24]); end
      n_cmp++; if (a.rr_ptr !== 2'd1) begin n_bad++; $display("FAIL ms_rr_hold got %0d exp 1", a.rr_ptr); end
      a.mode = 1'b1; a.in_sel = 2'd3; a.in_data = 8'h71;
      tick;
      a.in_valid = 1'b0;
      n_cmp++; if (a.out_valid !== 4'b0010 || a.out_data[15:8] !== 8'h71) begin n_bad++; $display("FAIL ms_rr_beat got %b/%h exp 0010/71", a.out_valid, a.out_data[15:8]); end
      n_cmp++; if (a.rr_ptr !== 2'd2) begin n_bad++; $display("FAIL ms_rr_next got %0d exp 2", a.rr_ptr); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset;
      test_sel_fanout;
      test_backpressure;
      test_rr;
      test_err_sat;
      test_reset_mid;
      test_mode_switch;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake, the successor to the fixed 4-way combinational demux. One input stream of DATA_W bits is steered to one of N_CH output channels, either by an explicit per-beat select or by an internal round-robin pointer. Each channel owns a one-entry output register, so back-pressure on one channel never corrupts data already issued to another. It sits between a single producer and N independent consumers.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (≥1)
- N_CH, 4, number of output channels (2..16, not required to be a power of two)
- CNT_W, 8, width of the saturating error counter
- SEL_W, $clog2(N_CH), derived localparam, not overridable

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = explicit select (MODE_SEL), 1 = round-robin (MODE_RR)
- in_data  in  DATA_W  input payload
- in_sel  in  SEL_W  target channel, used only in MODE_SEL
- in_valid  in  1  input beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- out_data  out  N_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W]
- out_valid  out  N_CH  per-channel valid
- out_ready  in  N_CH  per-channel ready
- rr_ptr  out  SEL_W  current round-robin target
- err_cnt  out  CNT_W  count of dropped out-of-range beats, saturating

## Operation
- Target tgt = (mode ? rr_ptr : in_sel), evaluated combinationally each cycle.
- Channel k slot is free when !out_valid[k] or (out_valid[k] & out_ready[k]).
- in_ready = !rst & (tgt ≥ N_CH or slot tgt free). in_ready may depend combinationally on out_ready, mode, in_sel.
- Accept (in_valid & in_ready, tgt < N_CH): next cycle out_valid[tgt]=1, out_data[tgt]=in_data.
- Channel k drains on out_valid[k] & out_ready[k]; clears out_valid[k] unless refilled in the same cycle (simultaneous drain + fill → valid stays 1, new data loaded).
- While out_valid[k] & !out_ready[k], out_data[k] held stable.
- Out-of-range select (MODE_SEL, in_sel ≥ N_CH): beat accepted and dropped, err_cnt += 1, saturates at 2^CNT_W−1; no channel changes.
- MODE_RR: rr_ptr advances on each accepted beat, N_CH−1 wraps to 0. rr_ptr only ever holds 0..N_CH−1. A blocked target stalls the input; no skipping to another free channel.
- MODE_SEL: rr_ptr holds its value. Mode switching is permitted any cycle; takes effect on the same cycle's tgt.
- Reset: out_valid = 0, out_data = 0, rr_ptr = 0, err_cnt = 0, in_ready = 0 while rst high. Beats in flight at reset are discarded; no partial delivery.

## Timing
- Latency: accepted beat visible on out_valid/out_data exactly 1 cycle after acceptance.
- Throughput: 1 beat/cycle sustained when the target channel drains every cycle or targets rotate over free channels.
- First cycle after rst deasserts: in_ready may be 1 and accept.
- No combinational path from in_valid/in_data to any output other than none; out_* are registered.

## Structure
- Package demux_pkg: mode constants MODE_SEL=1'b0, MODE_RR=1'b1; helper function for the rr wrap.
- Sub-module demux_chan_reg: one-entry valid/data register with fill, drain, hold; instantiated N_CH times via generate.
- Top holds tgt decode, in_ready logic, rr_ptr, err_cnt.

## Test plan
- MODE_SEL, N_CH=4, all out_ready=1: send 0xA0..0xA3 with in_sel 0..3 on consecutive cycles → each appears on its channel 1 cycle later, in_ready stays 1.
- Back-pressure: out_ready[2]=0, two beats 0x11, 0x22 to ch2 → 0x11 held on ch2, in_ready=0 for second beat until out_ready[2]=1; then 0x22 loaded the same cycle 0x11 drains, out_valid[2] stays 1.
- MODE_RR, N_CH=3: six beats 1..6, all ready → ch0 gets 1,4; ch1 gets 2,5; ch2 gets 3,6; rr_ptr 0→1→2→0→1→2→0.
- N_CH=3, MODE_SEL, in_sel=3 for 300 beats with CNT_W=8 → in_ready=1, no out_valid, err_cnt saturates at 255.
- Reset mid-operation: ch1 holding 0x55 stalled, rr_ptr=2, err_cnt=4, assert rst one cycle → all out_valid=0, out_data=0, rr_ptr=0, err_cnt=0, in_ready=0 during rst.
- Mode switch: MODE_RR with rr_ptr=1, switch to MODE_SEL in_sel=3 for one beat, back to MODE_RR → beat lands on ch3, rr_ptr still 1 and next RR beat lands on ch1.
